// File: rtl/mcp2515_spi_target.sv
// mcp2515_spi_target
// -----------------------------------------------------------------------------
// SPI responder that emulates the register-level SPI interface of an MCP2515
// CAN controller. It decodes RESET (0xC0), WRITE (0x02), READ (0x03) and,
// when the MCP_BITMOD_EN macro is defined, BIT MODIFY (0x05) frames. It holds
// a 128-byte register file with the CANCTRL/CANSTAT, CANINTF and TXB0CTRL
// side effects. SPI mode is 1,1: sck idles high, si is sampled on the rising
// edge, and so changes on the falling edge.
//
// Optional feature macro: MCP_BITMOD_EN (enables the BIT MODIFY command).
//
// Parameters:
//   RST_CANCTRL  CANCTRL value after reset or after the RESET command
//   SYNC_STAGES  synchronizer depth for cs/sck/si (2 or 3)
//
// Ports:
//   clk50    in   system clock
//   rst      in   synchronous active-high reset
//   cs       in   SPI chip select, active low, asynchronous
//   sck      in   SPI clock, idles high
//   si       in   SPI data from the initiator
//   so       out  SPI data to the initiator (1 unless a read is streaming)
//   busy     out  high while a frame is in progress
//   tx_req   out  one-cycle pulse when TXB0CTRL.TXREQ rises
//   tx_done  in   pulse: clears TXB0CTRL.TXREQ and sets CANINTF.TX0IF
//   rx_load  in   pulse: sets CANINTF.RX0IF
//   int_n    out  active-low interrupt, ~|(CANINTE & CANINTF)
//   opmode   out  CANSTAT[7:5]
// -----------------------------------------------------------------------------
module mcp2515_spi_target #(
    parameter logic [7:0] RST_CANCTRL = 8'h87,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       cs,
    input  logic       sck,
    input  logic       si,
    output logic       so,
    output logic       busy,
    output logic       tx_req,
    input  logic       tx_done,
    input  logic       rx_load,
    output logic       int_n,
    output logic [2:0] opmode
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WR, RD, MASK, BDATA, SKIP} state_t;
    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_BITMOD} op_t;

    localparam logic [6:0] A_CANSTAT  = 7'h0E;
    localparam logic [6:0] A_CANCTRL  = 7'h0F;
    localparam logic [6:0] A_CANINTE  = 7'h2B;
    localparam logic [6:0] A_CANINTF  = 7'h2C;
    localparam logic [6:0] A_TXB0CTRL = 7'h30;

    // Synchronizers plus one extra flop per edge-detected pin
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, si_sync;
    logic                   cs_prev, sck_prev;
    logic                   cs_s, sck_s, si_s;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    always_ff @(posedge clk50) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            si_sync  <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            si_sync  <= {si_sync[SYNC_STAGES-2:0], si};
            cs_prev  <= cs_s;
            sck_prev <= sck_s;
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign si_s     = si_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;

    // Frame state
    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic [6:0] ptr, ptr_d;
    logic [7:0] mask_q, mask_d;
    logic       reset_armed, arm_d;

    logic [7:0] regs [0:127];

    logic       byte_done;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_load;
    logic [6:0] rd_addr;
    logic       reset_regs;

    // rx_byte is the full byte including the bit being sampled right now,
    // so decode can act on the same cycle as the 8th rise.
    assign rx_byte   = {rx_sr[6:0], si_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state_q != IDLE);

    // Next-state and per-byte actions. A cs rise always aborts the frame;
    // otherwise decisions are taken only when a byte completes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ptr_d   = ptr;
        mask_d  = mask_q;
        arm_d   = reset_armed;
        wr_en   = 1'b0;
        wr_addr = ptr;
        wr_data = rx_byte;
        rd_load = 1'b0;
        rd_addr = ptr;

        if (state_q == IDLE) begin
            arm_d = 1'b0;
            if (cs_fall) begin
                state_d = CMD;
            end
        end else if (cs_rise) begin
            state_d = IDLE;
        end else if (byte_done) begin
            case (state_q)
                CMD: begin
                    case (rx_byte)
                        8'hC0: begin
                            state_d = SKIP;
                            arm_d   = 1'b1;
                        end
                        8'h02: begin
                            state_d = ADDR;
                            op_d    = OP_WRITE;
                        end
                        8'h03: begin
                            state_d = ADDR;
                            op_d    = OP_READ;
                        end
`ifdef MCP_BITMOD_EN
                        8'h05: begin
                            state_d = ADDR;
                            op_d    = OP_BITMOD;
                        end
`endif
                        default: state_d = SKIP;
                    endcase
                end
                ADDR: begin
                    ptr_d = rx_byte[6:0];
                    case (op_q)
                        OP_WRITE: state_d = WR;
                        OP_READ: begin
                            // Preload the first read byte from the address just received
                            state_d = RD;
                            rd_load = 1'b1;
                            rd_addr = rx_byte[6:0];
                            ptr_d   = rx_byte[6:0] + 7'd1;
                        end
                        default: state_d = MASK;
                    endcase
                end
                WR: begin
                    wr_en = 1'b1;
                    ptr_d = ptr + 7'd1;
                end
                RD: begin
                    rd_load = 1'b1;
                    ptr_d   = ptr + 7'd1;
                end
                MASK: begin
                    mask_d  = rx_byte;
                    state_d = BDATA;
                end
                BDATA: begin
                    // Pointer stays put; anything after the data byte is ignored
                    wr_en   = 1'b1;
                    wr_data = (regs[ptr] & ~mask_q) | (rx_byte & mask_q);
                    state_d = SKIP;
                end
                default: ;
            endcase
        end
    end

    // Frame registers and the two shift registers. tx_sr is not shifted on
    // the first fall of each byte so its MSB, loaded after the previous byte
    // completed, is still presented for the first rise.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_WRITE;
            bit_cnt     <= 3'd0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'hFF;
            ptr         <= 7'd0;
            mask_q      <= 8'h00;
            reset_armed <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ptr         <= ptr_d;
            mask_q      <= mask_d;
            reset_armed <= arm_d;

            if (state_q == IDLE) begin
                bit_cnt <= 3'd0;
                rx_sr   <= 8'h00;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte;
            end

            if (rd_load) begin
                tx_sr <= regs[rd_addr];
            end else if (sck_fall && (bit_cnt != 3'd0) && (state_q != IDLE)) begin
                tx_sr <= {tx_sr[6:0], 1'b1};
            end
        end
    end

    // An armed RESET command takes effect on the cs rise that ends its frame
    assign reset_regs = rst || (cs_rise && reset_armed);

    // Register file. Hardware events are applied first so that a same-cycle
    // SPI write to the same byte overrides them.
    always_ff @(posedge clk50) begin
        if (reset_regs) begin
            for (int i = 0; i < 128; i++) begin
                regs[i] <= 8'h00;
            end
            regs[A_CANCTRL] <= RST_CANCTRL;
            regs[A_CANSTAT] <= {RST_CANCTRL[7:5], 5'b0};
            tx_req          <= 1'b0;
        end else begin
            tx_req <= 1'b0;
            if (tx_done) begin
                regs[A_TXB0CTRL][3] <= 1'b0;
                regs[A_CANINTF][2]  <= 1'b1;
            end
            if (rx_load) begin
                regs[A_CANINTF][0] <= 1'b1;
            end
            // CANSTAT is read-only from SPI; CANCTRL mirrors its mode bits there
            if (wr_en && (wr_addr != A_CANSTAT)) begin
                regs[wr_addr] <= wr_data;
                if (wr_addr == A_CANCTRL) begin
                    regs[A_CANSTAT][7:5] <= wr_data[7:5];
                end
                if ((wr_addr == A_TXB0CTRL) && wr_data[3] && !regs[A_TXB0CTRL][3]) begin
                    tx_req <= 1'b1;
                end
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clk50) begin
        if (rst) begin
            busy   <= 1'b0;
            int_n  <= 1'b1;
            opmode <= RST_CANCTRL[7:5];
        end else begin
            busy   <= ~cs_s;
            int_n  <= ~|(regs[A_CANINTE] & regs[A_CANINTF]);
            opmode <= regs[A_CANSTAT][7:5];
        end
    end

    assign so = (state_q == RD) ? tx_sr[7] : 1'b1;

endmodule

// File: tb/tb_mcp2515_spi_target.sv
// tb_mcp2515_spi_target
// -----------------------------------------------------------------------------
// Self-checking bench for mcp2515_spi_target. Acts as an SPI mode 1,1
// initiator at 1 MHz. Expected read bytes are pushed to a scoreboard queue
// before each read frame and popped as the frame returns data. Status pins
// are compared against fixed expected values. Honours MCP_BITMOD_EN.
// -----------------------------------------------------------------------------
module tb_mcp2515_spi_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       sck;
    logic       si;
    logic       so;
    logic       busy;
    logic       txReq;
    logic       txDone;
    logic       rxLoad;
    logic       intN;
    logic [2:0] opmode;

    int vectors = 0;
    int miscompares = 0;
    int txReqCount = 0;

    logic [7:0] txBuf [0:7];
    logic [7:0] rxBuf [0:7];
    logic [7:0] expQ [$];

    mcp2515_spi_target #(
        .RST_CANCTRL(8'h87),
        .SYNC_STAGES(2)
    ) dut (
        .clk50  (clk),
        .rst    (rst),
        .cs     (cs),
        .sck    (sck),
        .si     (si),
        .so     (so),
        .busy   (busy),
        .tx_req (txReq),
        .tx_done(txDone),
        .rx_load(rxLoad),
        .int_n  (intN),
        .opmode (opmode)
    );

    // 50 MHz system clock
    always #10 clk = ~clk;

    // Count every cycle tx_req is high so pulse width can be checked
    always @(posedge clk) begin
        if (txReq) txReqCount <= txReqCount + 1;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
        end
    endtask

    // One SPI frame: nBytes whole bytes from txBuf, then extraBits leading
    // bits of txBuf[nBytes]. so is captured just before each rising edge.
    task automatic applyStimulus(input int nBytes, input int extraBits);
        cs = 1'b0;
        waitClk(10);
        for (int i = 0; i <= nBytes; i++) begin
            for (int b = 7; b >= 0; b--) begin
                if (i < nBytes || (7 - b) < extraBits) begin
                    sck = 1'b0;
                    si  = txBuf[i][b];
                    waitClk(25);
                    rxBuf[i][b] = so;
                    sck = 1'b1;
                    waitClk(25);
                end
            end
        end
        waitClk(10);
        cs = 1'b1;
        si = 1'b1;
        waitClk(20);
    endtask

    task automatic spiWrite(input logic [6:0] addr, input logic [7:0] data);
        txBuf[0] = 8'h02;
        txBuf[1] = {1'b0, addr};
        txBuf[2] = data;
        applyStimulus(3, 0);
    endtask

    task automatic spiRead(input logic [6:0] addr, input int n, input string tag);
        logic [7:0] expected;
        txBuf[0] = 8'h03;
        txBuf[1] = {1'b0, addr};
        for (int k = 0; k < n; k++) txBuf[2 + k] = 8'h00;
        applyStimulus(2 + n, 0);
        for (int k = 0; k < n; k++) begin
            expected = expQ.pop_front();
            checkOutput($sformatf("%s[%0d]", tag, k), rxBuf[2 + k], expected);
        end
    endtask

    task automatic pulse(input bit isTxDone);
        @(negedge clk);
        if (isTxDone) txDone = 1'b1; else rxLoad = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
        rxLoad = 1'b0;
        waitClk(3);
    endtask

    initial begin
        int txBefore;
        rst    = 1'b1;
        cs     = 1'b1;
        sck    = 1'b1;
        si     = 1'b1;
        txDone = 1'b0;
        rxLoad = 1'b0;
        waitClk(5);
        rst = 1'b0;
        waitClk(5);

        // Reset state
        checkOutput("rst_so",     {7'd0, so},    8'h01);
        checkOutput("rst_busy",   {7'd0, busy},  8'h00);
        checkOutput("rst_txreq",  {7'd0, txReq}, 8'h00);
        checkOutput("rst_intn",   {7'd0, intN},  8'h01);
        checkOutput("rst_opmode", {5'd0, opmode}, 8'h04);

        // busy follows cs during an empty frame
        cs = 1'b0;
        waitClk(8);
        checkOutput("busy_frame", {7'd0, busy}, 8'h01);
        cs = 1'b1;
        waitClk(8);
        checkOutput("busy_idle", {7'd0, busy}, 8'h00);

        // Single write then read back
        spiWrite(7'h2A, 8'h03);
        expQ.push_back(8'h03);
        spiRead(7'h2A, 1, "rd_2A");

        // Aborted data byte leaves the target untouched
        txBuf[0] = 8'h02;
        txBuf[1] = 8'h2A;
        txBuf[2] = 8'hFF;
        applyStimulus(2, 4);
        expQ.push_back(8'h03);
        spiRead(7'h2A, 1, "partial_2A");

        // Burst write wrapping 0x7F -> 0x00
        txBuf[0] = 8'h02;
        txBuf[1] = 8'h7F;
        txBuf[2] = 8'h11;
        txBuf[3] = 8'h22;
        applyStimulus(4, 0);
        expQ.push_back(8'h11);
        expQ.push_back(8'h22);
        spiRead(7'h7F, 2, "wrap");

        // CANCTRL mode bits mirror into CANSTAT; CANSTAT itself is read-only
        spiWrite(7'h0F, 8'h04);
        checkOutput("opmode_cfg", {5'd0, opmode}, 8'h00);
        expQ.push_back(8'h00);
        spiRead(7'h0E, 1, "canstat");
        spiWrite(7'h0E, 8'hFF);
        expQ.push_back(8'h00);
        spiRead(7'h0E, 1, "canstat_ro");

        // RESET command restores the register file
        txBuf[0] = 8'hC0;
        applyStimulus(1, 0);
        checkOutput("opmode_reset", {5'd0, opmode}, 8'h04);
        expQ.push_back(8'h87);
        spiRead(7'h0F, 1, "canctrl_reset");
        expQ.push_back(8'h80);
        spiRead(7'h0E, 1, "canstat_reset");
        expQ.push_back(8'h00);
        spiRead(7'h2A, 1, "2A_reset");

        // Interrupt from rx_load, cleared by writing CANINTF
        spiWrite(7'h2B, 8'h01);
        checkOutput("intn_enable", {7'd0, intN}, 8'h01);
        pulse(1'b0);
        checkOutput("intn_rx", {7'd0, intN}, 8'h00);
        expQ.push_back(8'h01);
        spiRead(7'h2C, 1, "canintf_rx");
        spiWrite(7'h2C, 8'h00);
        checkOutput("intn_clear", {7'd0, intN}, 8'h01);

        // TXREQ pulse and tx_done completion
        txBefore = txReqCount;
        spiWrite(7'h30, 8'h08);
        checkOutput("txreq_pulses", 8'(txReqCount - txBefore), 8'h01);
        pulse(1'b1);
        expQ.push_back(8'h00);
        spiRead(7'h30, 1, "txb0ctrl_done");
        expQ.push_back(8'h04);
        spiRead(7'h2C, 1, "canintf_tx");
        checkOutput("intn_tx_masked", {7'd0, intN}, 8'h01);

        // BIT MODIFY (or ignored unknown command without the feature)
        spiWrite(7'h2A, 8'hF0);
        txBuf[0] = 8'h05;
        txBuf[1] = 8'h2A;
        txBuf[2] = 8'h0F;
        txBuf[3] = 8'h05;
        applyStimulus(4, 0);
`ifdef MCP_BITMOD_EN
        expQ.push_back(8'hF5);
`else
        expQ.push_back(8'hF0);
`endif
        spiRead(7'h2A, 1, "bitmod");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
